hazard_redirect_ctrl: RTL
=========================

Name: hazard_redirect_ctrl

Overview:
Pipeline control unit for the 5-stage core. It decides execute-stage redirects (branch/jump), load-use stalls and memory-busy freezes, and drives pcSrcE plus the stall/flush lines for the fetch, decode and execute registers. It absorbs the execute-stage branch gate into a sequenced controller with multi-cycle flush and stall windows.

Parameters:
REG_W, 4, register index width for rdE/rs1D/rs2D
FLUSH_EXTRA, 0, extra cycles flushD is held after a redirect (for fetch-latency memories); range 0..7
LOAD_LAT, 1, total load-use stall cycles; range 1..7

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-low reset
validE  in  1  execute-stage instruction is valid (not a bubble)
jumpE  in  1  unconditional jump in E
branchE  in  1  conditional branch in E
negative  in  1  ALU negative flag for the E compare
memReadE  in  1  E instruction is a load
rdE  in  REG_W  destination register of E
rs1D  in  REG_W  source 1 of D
rs2D  in  REG_W  source 2 of D
memBusyM  in  1  data memory not ready; whole pipeline must freeze
pcSrcE  out  1  select branch/jump target for next PC
stallF  out  1  hold PC
stallD  out  1  hold IF/ID register
stallE  out  1  hold ID/EX register
flushD  out  1  clear IF/ID register
flushE  out  1  clear ID/EX register

Behaviour:
- Clock, reset and state update: one clock, clk. reset is synchronous and active-low. On reset==0 at a clk edge: state=RUN, cnt=0. While reset==0, outputs are forced to: pcSrcE=0, all stalls 0, flushD=1, flushE=1.
- Outputs are combinational from state and inputs. Redirect has zero added latency: pcSrcE asserts in the same cycle E is evaluated.
- takeE = validE & (jumpE | (branchE & !negative)). The branch is taken when the compare result is >= 0.
- loadUse = validE & memReadE & (rdE!=0) & (rdE==rs1D | rdE==rs2D).
- States and cnt: RUN, REDIR, LUSTALL, MEMWAIT. cnt is a 3-bit down-counter.
- RUN, priority memBusyM > takeE > loadUse:
  - memBusyM: stallF=stallD=stallE=1, no flush, pcSrcE=0 (E is held and re-evaluated later); next state MEMWAIT.
  - takeE: pcSrcE=1, flushD=1, flushE=1. If FLUSH_EXTRA>0, go to REDIR with cnt=FLUSH_EXTRA; else stay in RUN.
  - loadUse: stallF=stallD=1, flushE=1 (insert bubble). If LOAD_LAT>1, go to LUSTALL with cnt=LOAD_LAT-1; else stay in RUN.
  - none of these: all outputs 0.
- REDIR:
  - flushD=1; takeE and loadUse are ignored (E holds a bubble).
  - cnt decrements each cycle; return to RUN after the cycle in which cnt==1.
  - If memBusyM: stallF=stallD=stallE=1 and flushD=1; cnt frozen.
- LUSTALL:
  - stallF=stallD=1, flushE=1; cnt decrements each cycle; exit to RUN after the cnt==1 cycle.
  - If memBusyM: stallE=1 as well; cnt frozen. takeE is ignored.
- MEMWAIT:
  - While memBusyM=1: stallF=stallD=stallE=1, no flush.
  - On the first cycle memBusyM=0, RUN rules apply combinationally and set the next state. The held E instruction is resolved without a lost cycle.
- Reset mid-window: any state returns to RUN, and the counter clears on the same edge.
- A stall and a flush on the same register are never asserted together, except in REDIR under memBusyM, where flushD takes precedence.

Optional Feature:
CTRL_STATS_EN
- Defined: adds outputs redirCnt, luStallCnt and memStallCnt, each 32-bit.
  - Each is cleared by reset.
  - Increments: redirCnt on every cycle pcSrcE=1; luStallCnt on every cycle with a load-use stall (RUN loadUse or LUSTALL); memStallCnt on every cycle memBusyM causes stallE=1.
  - All counters wrap at 2^32.
- Undefined: these ports and registers do not exist; control behaviour is identical.

Test Plan:
- Taken branch: validE=1, branchE=1, negative=0, FLUSH_EXTRA=2 -> same cycle pcSrcE=1, flushD=flushE=1; next 2 cycles flushD=1 and pcSrcE=0; then RUN.
- Not-taken branch: branchE=1, negative=1 -> pcSrcE=0, no flush. jumpE=1 with validE=0 -> pcSrcE=0.
- Load-use: memReadE=1, rdE=5, rs2D=5, LOAD_LAT=2 -> 2 cycles of stallF=stallD=flushE=1. Repeat with rdE=0 -> no stall.
- memBusyM held 3 cycles while jumpE=1 in E -> 3 cycles of all stalls with pcSrcE=0; on the 4th cycle pcSrcE=1 and flushD=flushE=1.
- Priority: takeE and loadUse asserted together -> redirect only, no stallF. reset=0 during LUSTALL -> next cycle in RUN, outputs 0.
- With CTRL_STATS_EN: 4 taken branches plus 2 load-use events (LOAD_LAT=1) -> redirCnt=4, luStallCnt=2.

Source files
------------

// File: rtl/hazard_redirect_ctrl_if.sv
// rtl/hazard_redirect_ctrl_if.sv - pipeline hazard signals between datapath and hazard_redirect_ctrl
interface hazard_redirect_ctrl_if #(parameter int REG_W = 4);
  logic             validE;
  logic             jumpE;
  logic             branchE;
  logic             negative;
  logic             memReadE;
  logic [REG_W-1:0] rdE;
  logic [REG_W-1:0] rs1D;
  logic [REG_W-1:0] rs2D;
  logic             memBusyM;
  logic             pcSrcE;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             flushD;
  logic             flushE;

  modport master (
    output validE, jumpE, branchE, negative, memReadE, rdE, rs1D, rs2D, memBusyM,
    input  pcSrcE, stallF, stallD, stallE, flushD, flushE
  );

  modport slave (
    input  validE, jumpE, branchE, negative, memReadE, rdE, rs1D, rs2D, memBusyM,
    output pcSrcE, stallF, stallD, stallE, flushD, flushE
  );
endinterface

// File: rtl/hazard_redirect_ctrl.sv
// rtl/hazard_redirect_ctrl.sv - execute-stage redirect, load-use stall and memory freeze sequencer
// Optional CTRL_STATS_EN adds redirCnt/luStallCnt/memStallCnt event counters.
module hazard_redirect_ctrl #(
  parameter int REG_W       = 4,
  parameter int FLUSH_EXTRA = 0,
  parameter int LOAD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_redirect_ctrl_if.slave bus
`ifdef CTRL_STATS_EN
  ,
  output logic [31:0]          redirCnt,
  output logic [31:0]          luStallCnt,
  output logic [31:0]          memStallCnt
`endif
);

  typedef enum logic [1:0] {RUN, REDIR, LUSTALL, MEMWAIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       take_e;
  logic       load_use;
  logic       lu_evt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lu_evt       = 1'b0;
    bus.pcSrcE   = 1'b0;
    bus.stallF   = 1'b0;
    bus.stallD   = 1'b0;
    bus.stallE   = 1'b0;
    bus.flushD   = 1'b0;
    bus.flushE   = 1'b0;
    take_e   = bus.validE & (bus.jumpE | (bus.branchE & ~bus.negative));
    load_use = bus.validE & bus.memReadE & (bus.rdE != {REG_W{1'b0}}) &
               ((bus.rdE == bus.rs1D) | (bus.rdE == bus.rs2D));

    if (!reset) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
      state_d    = RUN;
      cnt_d      = 3'd0;
    end else begin
      case (state_q)
        REDIR: begin
          bus.flushD = 1'b1;
          if (bus.memBusyM) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
        end
        LUSTALL: begin
          lu_evt     = 1'b1;
          bus.stallF = 1'b1;
          bus.stallD = 1'b1;
          // Under a memory freeze the bubble is held rather than re-inserted.
          if (bus.memBusyM) begin
            bus.stallE = 1'b1;
          end else begin
            bus.flushE = 1'b1;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
        end
        default: begin
          // MEMWAIT resolves the held E instruction with RUN rules once memory is ready.
          if (bus.memBusyM) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
            state_d    = MEMWAIT;
          end else if (take_e) begin
            bus.pcSrcE = 1'b1;
            bus.flushD = 1'b1;
            bus.flushE = 1'b1;
            state_d    = (FLUSH_EXTRA > 0) ? REDIR : RUN;
            cnt_d      = 3'(FLUSH_EXTRA);
          end else if (load_use) begin
            lu_evt     = 1'b1;
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.flushE = 1'b1;
            state_d    = (LOAD_LAT > 1) ? LUSTALL : RUN;
            cnt_d      = 3'(LOAD_LAT - 1);
          end else begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTRL_STATS_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] mem_cnt_q, mem_cnt_d;

  always_comb begin
    redir_cnt_d = redir_cnt_q + {31'd0, bus.pcSrcE};
    lu_cnt_d    = lu_cnt_q + {31'd0, lu_evt};
    mem_cnt_d   = mem_cnt_q + {31'd0, bus.memBusyM};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      redir_cnt_q <= 32'd0;
      lu_cnt_q    <= 32'd0;
      mem_cnt_q   <= 32'd0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
    end
  end

  assign redirCnt    = redir_cnt_q;
  assign luStallCnt  = lu_cnt_q;
  assign memStallCnt = mem_cnt_q;
`endif

endmodule
